// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared colour type, default geometry and sync polarity for the VGA pixel path
package vga_pkg;

    typedef logic [11:0] rgb12_t;

    localparam int RGB_R_LSB = 8;
    localparam int RGB_G_LSB = 4;
    localparam int RGB_B_LSB = 0;

    localparam int DEF_FB_W        = 320;
    localparam int DEF_FB_H        = 240;
    localparam int DEF_SCALE_SHIFT = 1;

    localparam logic SYNC_ACTIVE = 1'b0;

    // Bit positions inside the latency-matched sync bundle
    localparam int SD_HS = 0;
    localparam int SD_VS = 1;
    localparam int SD_EN = 2;
    localparam int SD_IN = 3;
    localparam int SD_W  = 4;

    function automatic rgb12_t grey(input logic [3:0] level);
        rgb12_t c;
        c = '0;
        c[RGB_R_LSB +: 4] = level;
        c[RGB_G_LSB +: 4] = level;
        c[RGB_B_LSB +: 4] = level;
        return c;
    endfunction

endpackage

// File: rtl/vga_pixel_pipe_if.sv
// rtl/vga_pixel_pipe_if.sv - framebuffer read port between the pixel pipe and its BRAM
interface vga_pixel_pipe_if #(
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 4
);
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_re;
    logic [PIX_W-1:0]  fb_rdata;

    modport master (output fb_addr, output fb_re, input fb_rdata);
    modport slave  (input fb_addr, input fb_re, output fb_rdata);
endinterface

// File: rtl/vga_sync_delay.sv
// rtl/vga_sync_delay.sv - resettable shift register keeping hs/vs/en/inrange aligned with pipelined data
module vga_sync_delay
    import vga_pkg::*;
#(
    parameter int              DEPTH   = 3,
    parameter logic [SD_W-1:0] RST_VAL = 4'b0011
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [SD_W-1:0] d,
    output logic [SD_W-1:0] q
);

    logic [SD_W-1:0] taps [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= RST_VAL;
        end else begin
            taps[0] <= d;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign q = taps[DEPTH-1];

endmodule

// File: rtl/vga_pixel_pipe.sv
// rtl/vga_pixel_pipe.sv - scan coordinate to framebuffer address, palette lookup and aligned VGA outputs
module vga_pixel_pipe
    import vga_pkg::*;
#(
    parameter int FB_W        = DEF_FB_W,
    parameter int FB_H        = DEF_FB_H,
    parameter int SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter int ADDR_W      = 17,
    parameter int PIX_W       = 4,
    parameter int RD_LAT      = 1
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_hs,
    input  logic                    in_vs,
    input  logic                    in_en,
    input  logic [15:0]             in_x,
    input  logic [15:0]             in_y,
    vga_pixel_pipe_if.master        fb,
    input  logic                    pal_we,
    input  logic [PIX_W-1:0]        pal_addr,
    input  rgb12_t                  pal_wdata,
    input  rgb12_t                  border,
    output logic                    vga_hs,
    output logic                    vga_vs,
    output logic                    vga_de,
    output rgb12_t                  vga_rgb,
    output logic                    frame_irq
);

    localparam int LAT   = RD_LAT + 2;
    localparam int MUL_W = ADDR_W + 17;
    localparam int PAL_N = 2 ** PIX_W;
    localparam logic [SD_W-1:0] SD_RST = {1'b0, 1'b0, ~SYNC_ACTIVE, ~SYNC_ACTIVE};

    logic [15:0]       fx;
    logic [15:0]       fy;
    logic              inrange;
    logic [ADDR_W-1:0] addr_next;
    logic [SD_W-1:0]   sd_in;
    logic [SD_W-1:0]   sd_out;
    rgb12_t            pal [PAL_N];

    assign fx = in_x >> SCALE_SHIFT;
    assign fy = in_y >> SCALE_SHIFT;

    assign inrange = in_en && (32'(fx) < 32'(FB_W)) && (32'(fy) < 32'(FB_H));

    // Product is formed wide and then truncated; out-of-range coordinates never reach fb_addr
    assign addr_next = ADDR_W'(MUL_W'(fy) * MUL_W'(FB_W) + MUL_W'(fx));

    always_ff @(posedge clk) begin
        if (rst) begin
            fb.fb_addr <= '0;
            fb.fb_re   <= 1'b0;
        end else begin
            fb.fb_re <= inrange;
            if (inrange) fb.fb_addr <= addr_next;
        end
    end

    always_comb begin
        sd_in        = '0;
        sd_in[SD_HS] = in_hs;
        sd_in[SD_VS] = in_vs;
        sd_in[SD_EN] = in_en;
        sd_in[SD_IN] = inrange;
    end

    // One tap short of LAT: the output registers below form the final tap
    vga_sync_delay #(
        .DEPTH   (LAT - 1),
        .RST_VAL (SD_RST)
    ) u_sync_delay (
        .clk (clk),
        .rst (rst),
        .d   (sd_in),
        .q   (sd_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PAL_N; i++) pal[i] <= grey(4'(i));
        end else if (pal_we) begin
            pal[pal_addr] <= pal_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_hs    <= ~SYNC_ACTIVE;
            vga_vs    <= ~SYNC_ACTIVE;
            vga_de    <= 1'b0;
            vga_rgb   <= '0;
            frame_irq <= 1'b0;
        end else begin
            vga_hs    <= sd_out[SD_HS];
            vga_vs    <= sd_out[SD_VS];
            vga_de    <= sd_out[SD_EN];
            frame_irq <= (vga_vs != SYNC_ACTIVE) && (sd_out[SD_VS] == SYNC_ACTIVE);
            if (!sd_out[SD_EN])      vga_rgb <= '0;
            else if (!sd_out[SD_IN]) vga_rgb <= border;
            else                     vga_rgb <= pal[fb.fb_rdata];
        end
    end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// tb/tb_vga_pixel_pipe.sv - directed checks of two pipe instances (RD_LAT=1/FB_W=320 and RD_LAT=3/FB_W=256)
module tb_vga_pixel_pipe;

    logic        clk;
    logic        rst;
    logic        in_hs, in_vs, in_en;
    logic [15:0] in_x, in_y;
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [11:0] pal_wdata;
    logic [11:0] border;

    logic        a_hs, a_vs, a_de, a_irq;
    logic [11:0] a_rgb;
    logic        b_hs, b_vs, b_de, b_irq;
    logic [11:0] b_rgb;

    int checks = 0;
    int errors = 0;

    vga_pixel_pipe_if #(.ADDR_W(17), .PIX_W(4)) fb_a ();
    vga_pixel_pipe_if #(.ADDR_W(17), .PIX_W(4)) fb_b ();

    vga_pixel_pipe #(.FB_W(320), .FB_H(240), .SCALE_SHIFT(1), .ADDR_W(17), .PIX_W(4), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .in_hs(in_hs), .in_vs(in_vs), .in_en(in_en), .in_x(in_x), .in_y(in_y),
        .fb(fb_a), .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata), .border(border),
        .vga_hs(a_hs), .vga_vs(a_vs), .vga_de(a_de), .vga_rgb(a_rgb), .frame_irq(a_irq)
    );

    vga_pixel_pipe #(.FB_W(256), .FB_H(240), .SCALE_SHIFT(1), .ADDR_W(17), .PIX_W(4), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .in_hs(in_hs), .in_vs(in_vs), .in_en(in_en), .in_x(in_x), .in_y(in_y),
        .fb(fb_b), .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata), .border(border),
        .vga_hs(b_hs), .vga_vs(b_vs), .vga_de(b_de), .vga_rgb(b_rgb), .frame_irq(b_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Framebuffer contents: low address nibble, except address 965 which holds index 3
    function automatic logic [3:0] fb_pix(input logic [16:0] addr);
        if (addr == 17'd965) return 4'd3;
        return addr[3:0];
    endfunction

    logic [3:0] a_s0;
    logic [3:0] b_s0, b_s1, b_s2;

    always @(posedge clk) begin
        if (fb_a.fb_re) a_s0 <= fb_pix(fb_a.fb_addr);
        if (fb_b.fb_re) b_s0 <= fb_pix(fb_b.fb_addr);
        b_s1 <= b_s0;
        b_s2 <= b_s1;
    end

    assign fb_a.fb_rdata = a_s0;
    assign fb_b.fb_rdata = b_s2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic h, input logic v, input logic e, input logic [15:0] xx, input logic [15:0] yy);
        in_hs = h; in_vs = v; in_en = e; in_x = xx; in_y = yy;
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam int H_TOT = 40;
    localparam int V_TOT = 12;
    localparam int FRAME = H_TOT * V_TOT * 4;
    localparam int RUN   = 2 * FRAME + 16;

    logic [1:0] hist [0:RUN-1];

    initial begin
        int irq_a, irq_b, bad_da, bad_db, bad_ia, bad_ib;
        logic pvs_a, pvs_b;

        rst = 1'b1; pal_we = 1'b0; pal_addr = '0; pal_wdata = '0; border = 12'hF00;
        idle();
        tick(); tick();
        chk("rst_a_hs", 32'(a_hs), 32'd1);
        chk("rst_a_vs", 32'(a_vs), 32'd1);
        chk("rst_a_de", 32'(a_de), 32'd0);
        chk("rst_a_rgb", 32'(a_rgb), 32'h000);
        chk("rst_a_re", 32'(fb_a.fb_re), 32'd0);
        chk("rst_a_irq", 32'(a_irq), 32'd0);
        chk("rst_b_de", 32'(b_de), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_irq", 32'(a_irq), 32'd0);

        // Grey-ramp palette entry 5: x=10,y=0 -> address 5 on both instances
        drive(1, 1, 1, 16'd10, 16'd0); tick();
        chk("p5_a_addr", 32'(fb_a.fb_addr), 32'd5);
        chk("p5_a_re", 32'(fb_a.fb_re), 32'd1);
        chk("p5_b_addr", 32'(fb_b.fb_addr), 32'd5);
        idle(); tick();
        chk("p5_a_de_early", 32'(a_de), 32'd0);
        tick();
        chk("p5_a_rgb", 32'(a_rgb), 32'h555);
        chk("p5_a_de", 32'(a_de), 32'd1);
        tick(); tick();
        chk("p5_b_rgb", 32'(b_rgb), 32'h555);
        chk("p5_b_de", 32'(b_de), 32'd1);

        // x=10,y=7: a -> 3*320+5=965 (index 3), b -> 3*256+5=773 (index 5)
        drive(1, 1, 1, 16'd10, 16'd7); tick();
        chk("p965_a_addr", 32'(fb_a.fb_addr), 32'd965);
        chk("p965_b_addr", 32'(fb_b.fb_addr), 32'd773);
        idle(); tick(); tick();
        chk("p965_a_rgb", 32'(a_rgb), 32'h333);
        tick(); tick();
        chk("p773_b_rgb", 32'(b_rgb), 32'h555);

        // Far corner: a -> 239*320+319=76799; b out of its 256-wide area, address held
        drive(1, 1, 1, 16'd639, 16'd479); tick();
        chk("corner_a_addr", 32'(fb_a.fb_addr), 32'd76799);
        chk("corner_b_re", 32'(fb_b.fb_re), 32'd0);
        chk("corner_b_hold", 32'(fb_b.fb_addr), 32'd773);
        idle(); tick(); tick();
        chk("corner_a_rgb", 32'(a_rgb), 32'hFFF);
        tick(); tick();
        chk("corner_b_border", 32'(b_rgb), 32'hF00);

        // x=600,y=20: a -> 10*320+300=3500 (index 0xC), b outside -> border
        drive(1, 1, 1, 16'd600, 16'd20); tick();
        chk("x600_a_addr", 32'(fb_a.fb_addr), 32'd3500);
        chk("x600_b_re", 32'(fb_b.fb_re), 32'd0);
        idle(); tick(); tick();
        chk("x600_a_rgb", 32'(a_rgb), 32'hCCC);
        tick(); tick();
        chk("x600_b_rgb", 32'(b_rgb), 32'hF00);
        chk("x600_b_de", 32'(b_de), 32'd1);

        // Blanking with hsync low
        drive(0, 1, 0, 16'd0, 16'd0); tick();
        chk("blank_a_re", 32'(fb_a.fb_re), 32'd0);
        idle(); tick();
        chk("blank_a_hs_early", 32'(a_hs), 32'd1);
        tick();
        chk("blank_a_hs", 32'(a_hs), 32'd0);
        chk("blank_a_rgb", 32'(a_rgb), 32'h000);
        chk("blank_a_de", 32'(a_de), 32'd0);
        tick(); tick();
        chk("blank_b_hs", 32'(b_hs), 32'd0);

        // Palette write colliding with the stage-C lookup of index 3
        drive(1, 1, 1, 16'd10, 16'd7); tick();
        tick();
        idle(); pal_we = 1'b1; pal_addr = 4'd3; pal_wdata = 12'hABC; tick();
        chk("palwr_old", 32'(a_rgb), 32'h333);
        pal_we = 1'b0; tick();
        chk("palwr_new", 32'(a_rgb), 32'hABC);
        tick(); tick(); tick();

        // Miniature scanner: 40x12 pixels per frame, 32x8 active, pixel held 4 clk
        irq_a = 0; irq_b = 0; bad_da = 0; bad_db = 0; bad_ia = 0; bad_ib = 0;
        pvs_a = a_vs; pvs_b = b_vs;
        for (int c = 0; c < RUN; c++) begin
            if (c < 2 * FRAME) begin
                int h, v;
                logic e;
                h = (c / 4) % H_TOT;
                v = ((c / 4) / H_TOT) % V_TOT;
                e = (h < 32) && (v < 8);
                drive(!(h >= 34 && h < 38), !(v >= 9 && v < 11), e,
                      e ? 16'(h) : 16'd0, e ? 16'(v) : 16'd0);
            end else begin
                idle();
            end
            tick();
            hist[c] = {in_hs, in_vs};
            if (c >= 2 && {a_hs, a_vs} !== hist[c-2]) bad_da++;
            if (c >= 4 && {b_hs, b_vs} !== hist[c-4]) bad_db++;
            if (a_irq !== (pvs_a && !a_vs)) bad_ia++;
            if (b_irq !== (pvs_b && !b_vs)) bad_ib++;
            if (a_irq) irq_a++;
            if (b_irq) irq_b++;
            pvs_a = a_vs; pvs_b = b_vs;
        end
        chk("frame_irq_cnt_a", 32'(irq_a), 32'd2);
        chk("frame_irq_cnt_b", 32'(irq_b), 32'd2);
        chk("frame_irq_align_a", 32'(bad_ia), 32'd0);
        chk("frame_irq_align_b", 32'(bad_ib), 32'd0);
        chk("sync_delay_a", 32'(bad_da), 32'd0);
        chk("sync_delay_b", 32'(bad_db), 32'd0);

        // Reset in the middle of an active line
        drive(1, 1, 1, 16'd10, 16'd7); tick(); tick(); tick();
        rst = 1'b1; tick();
        chk("midrst_a_de", 32'(a_de), 32'd0);
        chk("midrst_a_rgb", 32'(a_rgb), 32'h000);
        chk("midrst_a_hs", 32'(a_hs), 32'd1);
        chk("midrst_a_re", 32'(fb_a.fb_re), 32'd0);
        chk("midrst_a_addr", 32'(fb_a.fb_addr), 32'd0);
        chk("midrst_b_rgb", 32'(b_rgb), 32'h000);
        rst = 1'b0;
        drive(1, 1, 1, 16'd4, 16'd0); tick();
        drive(1, 1, 1, 16'd6, 16'd0); tick();
        idle(); tick();
        chk("midrst_pal2", 32'(a_rgb), 32'h222);
        tick();
        chk("midrst_pal3", 32'(a_rgb), 32'h333);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
